// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: PC and counter widths,
// the resolve-unit state encoding and the prediction entry layout.
package bp_pkg;

    localparam int PC_W  = 5;
    localparam int CNT_W = 8;

    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_e;

    typedef struct packed {
        pc_t pc;
        pc_t next_pc;
    } pred_entry_t;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        cnt_t r;
        r = v;
        if (v != {CNT_W{1'b1}}) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// In-flight prediction FIFO, DEPTH entries of {pc, next_pc}.
// Ports: i_push/i_pop/i_clear, write data i_wpc/i_wnext,
//        head data o_rpc/o_rnext, status o_full/o_empty.
module bp_pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_clear,
    input  logic [PC_W-1:0] i_wpc,
    input  logic [PC_W-1:0] i_wnext,
    output logic [PC_W-1:0] o_rpc,
    output logic [PC_W-1:0] o_rnext,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    pred_entry_t  r_mem [DEPTH];

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    pred_entry_t   w_head;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_head   = r_mem[w_rd_idx];

    assign o_rpc   = w_head.pc;
    assign o_rnext = w_head.next_pc;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (w_wr_idx == w_rd_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; pointers alone define contents.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[w_wr_idx] <= '{pc: i_wpc, next_pc: i_wnext};
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against execute results, emits
// predictor updates, flush/redirect pulses and hit statistics.
// Ports: pred_* (prediction in), res_* (resolution in), upd_* (update
//        out), flush/redirect_pc, correct_cnt/total_cnt.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    output logic             pred_ready,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic [PC_W-1:0]  pred_next_pc,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [PC_W-1:0]  res_addr,
    output logic             upd_valid,
    output logic [PC_W-1:0]  upd_pc,
    output logic [PC_W-1:0]  upd_addr,
    output logic             upd_mispredict,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    bru_state_e      r_state;
    bru_state_e      w_state_nxt;

    logic            w_full;
    logic            w_empty;
    logic [PC_W-1:0] w_head_pc;
    logic [PC_W-1:0] w_head_next;

    logic            w_res_fire;
    logic            w_mispredict;
    logic            w_correct;
    logic            w_pred_ready;
    logic            w_push;
    logic            w_pop;

    logic            r_upd_valid;
    logic [PC_W-1:0] r_upd_pc;
    logic [PC_W-1:0] r_upd_addr;
    logic            r_upd_mis;
    logic [PC_W-1:0] r_redirect;
    cnt_t            r_correct;
    cnt_t            r_total;

    bp_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mispredict),
        .i_wpc   (pred_pc),
        .i_wnext (pred_next_pc),
        .o_rpc   (w_head_pc),
        .o_rnext (w_head_next),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_res_fire   = res_valid && !w_empty;
    assign w_mispredict = w_res_fire && (w_head_next != res_addr);
    assign w_correct    = w_res_fire && !w_mispredict;

    // A correct resolution frees the head slot in the same cycle,
    // so a full FIFO can still take a push alongside it.
    assign w_pred_ready = (r_state == ST_RUN) &&
                          (!w_full || w_correct);

    // Anything offered alongside a mispredict is wrong-path.
    assign w_push = pred_valid && w_pred_ready && !w_mispredict;
    assign w_pop  = w_correct;

    assign pred_ready = w_pred_ready;
    assign res_ready  = !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        flush       = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_mispredict) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush       = 1'b1;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_addr  <= '0;
            r_upd_mis   <= 1'b0;
            r_redirect  <= '0;
        end else begin
            r_upd_valid <= w_res_fire;
            if (w_res_fire) begin
                r_upd_pc   <= w_head_pc;
                r_upd_addr <= res_addr;
                r_upd_mis  <= w_mispredict;
            end
            if (w_mispredict) begin
                r_redirect <= res_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_correct <= '0;
            r_total   <= '0;
        end else begin
            if (w_res_fire) begin
                r_total <= sat_inc(r_total);
            end
            if (w_correct) begin
                r_correct <= sat_inc(r_correct);
            end
        end
    end

    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_addr       = r_upd_addr;
    assign upd_mispredict = r_upd_mis;
    assign redirect_pc    = r_redirect;
    assign correct_cnt    = r_correct;
    assign total_cnt      = r_total;

endmodule
